// File: rtl/lookup_pkg.sv
// Shared definitions for the priority selector: config register map,
// config FSM encodings, the candidate record and small helper functions.
package lookup_pkg;

   localparam logic [5:0] ADDR_LOOKUP_CNT = 6'h00;
   localparam logic [5:0] ADDR_HIT_CNT    = 6'h01;
   localparam logic [5:0] ADDR_MISS_CNT   = 6'h02;
   localparam logic [5:0] ADDR_CLEAR      = 6'h03;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_ACK   = 2'd3
   } cfg_state_t;

   typedef struct packed {
      logic       hit;
      logic [7:0] prior;
      logic [7:0] index;
   } cand_t;

   // Operand a always comes from the lower entry positions, so ties keep a.
   function automatic cand_t pick(cand_t a, cand_t b);
      return (b.hit && (!a.hit || (b.prior > a.prior))) ? b : a;
   endfunction

   function automatic logic [31:0] sat_inc(logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/prior_cmp.sv
// Registered 2:1 compare node of the priority reduction tree.
module prior_cmp
   import lookup_pkg::*;
(
   input  logic       clk,
   input  logic       a_hit,
   input  logic [7:0] a_prior,
   input  logic [7:0] a_index,
   input  logic       b_hit,
   input  logic [7:0] b_prior,
   input  logic [7:0] b_index,
   output logic       out_hit,
   output logic [7:0] out_prior,
   output logic [7:0] out_index
);

   cand_t a, b, win;

   assign a   = {a_hit, a_prior, a_index};
   assign b   = {b_hit, b_prior, b_index};
   assign win = pick(a, b);

   // NOTE: pure datapath with no reset -- the valid pipeline in the parent
   // decides whether these bits mean anything, so clearing them buys nothing.
   always_ff @(posedge clk) begin
      out_hit   <= win.hit;
      out_prior <= win.prior;
      out_index <= win.index;
   end

endmodule

// File: rtl/prior_sel.sv
// Pipelined highest-priority selector over N_ENTRY entry results, with
// saturating lookup/hit/miss counters behind a simple config handshake.
module prior_sel
   import lookup_pkg::*;
#(
   parameter int N_ENTRY = 8,
   parameter int LG_N    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 key_valid,
   input  logic [N_ENTRY-1:0]   entry_hit,
   input  logic [8*N_ENTRY-1:0] entry_prior,
   input  logic [8*N_ENTRY-1:0] entry_index,
   output logic                 result_valid,
   output logic                 result_hit,
   output logic [7:0]           result_prior,
   output logic [7:0]           result_index,
   input  logic                 cfg2sel_cs_n,
   input  logic                 cfg2sel_wr_rd,
   output logic                 sel2cfg_ack_n,
   input  logic [5:0]           cfg2sel_addr,
   input  logic [31:0]          cfg2sel_wdata,
   output logic [31:0]          sel2cfg_rdata
);

   logic            kv_d;
   logic [LG_N:0]   stage_vld;
   logic            leaf_hit   [N_ENTRY];
   logic [7:0]      leaf_prior [N_ENTRY];
   logic [7:0]      leaf_index [N_ENTRY];
   logic            node_hit   [1:N_ENTRY-1];
   logic [7:0]      node_prior [1:N_ENTRY-1];
   logic [7:0]      node_index [1:N_ENTRY-1];
   logic [31:0]     lookup_cnt, hit_cnt, miss_cnt;
   logic [31:0]     rd_mux;
   logic            clr_cnt, rd_load;
   cfg_state_t      state, state_nxt;
   logic            unused_wdata;

   // Writes only ever trigger the clear; the data word carries no meaning.
   assign unused_wdata = ^cfg2sel_wdata;

   // NOTE: sequential state is always assigned with <= so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         kv_d      <= 1'b0;
         stage_vld <= '0;
      end else begin
         kv_d      <= key_valid;
         stage_vld <= {stage_vld[LG_N-1:0], kv_d};
      end
   end

   always_ff @(posedge clk) begin
      if (kv_d) begin
         for (int i = 0; i < N_ENTRY; i++) begin
            leaf_hit[i]   <= entry_hit[i];
            leaf_prior[i] <= entry_prior[8*i +: 8];
            leaf_index[i] <= entry_index[8*i +: 8];
         end
      end
   end

   // Heap-ordered tree: node k compares children 2k (lower positions) and 2k+1.
   for (genvar k = 1; k < N_ENTRY; k++) begin : g_node
      logic       l_hit, r_hit;
      logic [7:0] l_prior, r_prior, l_index, r_index;

      if (2*k >= N_ENTRY) begin : g_leaf
         assign l_hit   = leaf_hit[2*k-N_ENTRY];
         assign l_prior = leaf_prior[2*k-N_ENTRY];
         assign l_index = leaf_index[2*k-N_ENTRY];
         assign r_hit   = leaf_hit[2*k+1-N_ENTRY];
         assign r_prior = leaf_prior[2*k+1-N_ENTRY];
         assign r_index = leaf_index[2*k+1-N_ENTRY];
      end else begin : g_inner
         assign l_hit   = node_hit[2*k];
         assign l_prior = node_prior[2*k];
         assign l_index = node_index[2*k];
         assign r_hit   = node_hit[2*k+1];
         assign r_prior = node_prior[2*k+1];
         assign r_index = node_index[2*k+1];
      end

      prior_cmp u_cmp (
         .clk       (clk),
         .a_hit     (l_hit),
         .a_prior   (l_prior),
         .a_index   (l_index),
         .b_hit     (r_hit),
         .b_prior   (r_prior),
         .b_index   (r_index),
         .out_hit   (node_hit[k]),
         .out_prior (node_prior[k]),
         .out_index (node_index[k])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_valid <= 1'b0;
         result_hit   <= 1'b0;
         result_prior <= '0;
         result_index <= '0;
      end else begin
         result_valid <= stage_vld[LG_N];
         result_hit   <= stage_vld[LG_N] & node_hit[1];
         result_prior <= (stage_vld[LG_N] && node_hit[1]) ? node_prior[1] : '0;
         result_index <= (stage_vld[LG_N] && node_hit[1]) ? node_index[1] : '0;
      end
   end

   // A clear wins over an increment landing on the same edge.
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         lookup_cnt <= '0;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
      end else if (result_valid) begin
         lookup_cnt <= sat_inc(lookup_cnt);
         if (result_hit) hit_cnt  <= sat_inc(hit_cnt);
         else            miss_cnt <= sat_inc(miss_cnt);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt     = state;
      sel2cfg_ack_n = 1'b1;
      clr_cnt       = 1'b0;
      rd_load       = 1'b0;
      case (state)
         ST_IDLE:  if (!cfg2sel_cs_n) state_nxt = cfg2sel_wr_rd ? ST_READ : ST_WRITE;
         ST_WRITE: begin
            clr_cnt   = (cfg2sel_addr == ADDR_CLEAR);
            state_nxt = ST_ACK;
         end
         ST_READ: begin
            rd_load   = 1'b1;
            state_nxt = ST_ACK;
         end
         ST_ACK: begin
            if (cfg2sel_cs_n) state_nxt = ST_IDLE;
            else              sel2cfg_ack_n = 1'b0;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (cfg2sel_addr)
         ADDR_LOOKUP_CNT: rd_mux = lookup_cnt;
         ADDR_HIT_CNT:    rd_mux = hit_cnt;
         ADDR_MISS_CNT:   rd_mux = miss_cnt;
         default:         rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)          sel2cfg_rdata <= '0;
      else if (rd_load) sel2cfg_rdata <= rd_mux;
   end

endmodule
